frame_tick_sync: RTL and testbench

//  Consumer end of the frame-rate divider output. Samples the slow toggling frame

---
 rtl/frame_tick_sync.sv | 117 +++++++++++
 tb/tb_frame_tick_sync.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_tick_sync.sv
// Frame tick consumer: synchronises the divided frame clock, turns its edges into
// one-cycle frame_start strobes and tracks renderer handshake, drops and tick loss.
module frame_tick_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int BOTH_EDGES  = 1,
  parameter int TIMEOUT     = 1000000,
  parameter int FC_W        = 16,
  parameter int DC_W        = 8
) (
  input  logic            clkin,
  input  logic            resetn,
  input  logic            tick_in,
  input  logic            render_done,
  input  logic            overrun_clr,
  output logic            frame_start,
  output logic            frame_busy,
  output logic [FC_W-1:0] frame_count,
  output logic [DC_W-1:0] dropped_count,
  output logic            overrun,
  output logic            tick_lost
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_START  = 2'd1;
  localparam logic [1:0] ST_RENDER = 2'd2;

  function automatic logic [DC_W-1:0] sat_inc_dc(input logic [DC_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [TO_W-1:0] sat_inc_to(input logic [TO_W-1:0] v);
    return (v == TO_MAX) ? v : v + 1'b1;
  endfunction

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   hist_p;
  logic                   tick_s;
  logic                   edge_p0;
  logic [1:0]             state;
  logic [1:0]             state_nx;
  logic                   drop;
  logic [TO_W-1:0]        to_cnt;

  // Stage: asynchronous tick_in into the clkin domain, plus edge history
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      sync_p <= '0;
      hist_p <= 1'b0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], tick_in};
      hist_p <= sync_p[SYNC_STAGES-1];
    end
  end

  assign tick_s  = sync_p[SYNC_STAGES-1];
  assign edge_p0 = (BOTH_EDGES != 0) ? (tick_s ^ hist_p) : (tick_s & ~hist_p);

  // Stage: frame handshake; an edge is consumed either as a new frame or as a drop
  always_comb begin
    state_nx = state;
    drop     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (edge_p0) state_nx = ST_START;
      end
      ST_START: begin
        state_nx = ST_RENDER;
        drop     = edge_p0;
      end
      ST_RENDER: begin
        if (render_done) state_nx = edge_p0 ? ST_START : ST_IDLE;
        else             drop     = edge_p0;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_IDLE;
      frame_start   <= 1'b0;
      frame_busy    <= 1'b0;
      frame_count   <= '0;
      dropped_count <= '0;
      overrun       <= 1'b0;
    end else begin
      state       <= state_nx;
      frame_start <= (state_nx == ST_START);
      frame_busy  <= (state_nx != ST_IDLE);
      if (state_nx == ST_START) frame_count <= frame_count + 1'b1;
      if (drop) begin
        dropped_count <= sat_inc_dc(dropped_count);
        overrun       <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  // Stage: tick watchdog; tick_lost follows the saturated count by one cycle
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      to_cnt    <= '0;
      tick_lost <= 1'b0;
    end else if (edge_p0) begin
      to_cnt    <= '0;
      tick_lost <= 1'b0;
    end else begin
      to_cnt    <= sat_inc_to(to_cnt);
      tick_lost <= (to_cnt == TO_MAX);
    end
  end

endmodule

// File: tb/tb_frame_tick_sync.sv
// Directed bench for frame_tick_sync: a queue of expected frame_count values is
// filled as ticks are driven and drained by a monitor on every frame_start.
module tb_frame_tick_sync;

  localparam int FCW = 4;
  localparam int DCW = 2;
  localparam int TOUT = 100;

  logic clkin, resetn, tick_in, tick_b, render_done, overrun_clr;
  logic fs, busy, ovr, lost;
  logic [FCW-1:0] fc;
  logic [DCW-1:0] dc;
  logic fs_b, busy_b, ovr_b, lost_b;
  logic [FCW-1:0] fc_b;
  logic [DCW-1:0] dc_b;

  int n_vec = 0;
  int n_err = 0;
  int exp_fc = 0;
  int exp_dc = 0;
  int pulses_b = 0;
  int exp_q[$];

  frame_tick_sync #(.SYNC_STAGES(2), .BOTH_EDGES(1), .TIMEOUT(TOUT), .FC_W(FCW), .DC_W(DCW)) dut (
    .clkin(clkin), .resetn(resetn), .tick_in(tick_in), .render_done(render_done),
    .overrun_clr(overrun_clr), .frame_start(fs), .frame_busy(busy), .frame_count(fc),
    .dropped_count(dc), .overrun(ovr), .tick_lost(lost));

  frame_tick_sync #(.SYNC_STAGES(2), .BOTH_EDGES(0), .TIMEOUT(TOUT), .FC_W(FCW), .DC_W(DCW)) dut_r (
    .clkin(clkin), .resetn(resetn), .tick_in(tick_b), .render_done(render_done),
    .overrun_clr(overrun_clr), .frame_start(fs_b), .frame_busy(busy_b), .frame_count(fc_b),
    .dropped_count(dc_b), .overrun(ovr_b), .tick_lost(lost_b));

  initial clkin = 1'b0;
  always #10 clkin = ~clkin;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clkin);
      #1;
    end
  endtask

  task automatic expect_frame();
    exp_fc = (exp_fc + 1) % (1 << FCW);
    exp_q.push_back(exp_fc);
  endtask

  task automatic done_pulse();
    render_done = 1'b1;
    step(1);
    render_done = 1'b0;
  endtask

  task automatic wait_start(input string tag, input int budget, output int n);
    n = 0;
    while (fs !== 1'b1 && n < budget) begin
      step(1);
      n++;
    end
    chk(tag, fs, 1'b1);
  endtask

  // Scoreboard drain: each strobe must match the oldest queued frame
  always @(negedge clkin) begin
    if (resetn === 1'b1 && fs === 1'b1) begin
      n_vec++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_frame_start: observed frame_count %0d expected no strobe", fc);
      end
      if (exp_q.size() != 0) chk("frame_count_at_start", fc, exp_q.pop_front());
      chk("busy_at_start", busy, 1'b1);
    end
    if (resetn === 1'b1 && fs_b === 1'b1) pulses_b++;
  end

  initial begin
    int n;
    tick_in = 1'b0; tick_b = 1'b0; render_done = 1'b0; overrun_clr = 1'b0; resetn = 1'b0;
    step(3);
    chk("rst_frame_start", fs, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_count", fc, 0);
    chk("rst_dropped", dc, 0);
    chk("rst_overrun", ovr, 1'b0);
    chk("rst_tick_lost", lost, 1'b0);
    resetn = 1'b1;
    step(2);

    // single frame: latency, busy, render_done
    tick_in = ~tick_in; expect_frame();
    wait_start("t1_start", 20, n);
    chk("t1_latency", n, 3);
    chk("t1_busy", busy, 1'b1);
    step(10);
    chk("t1_busy_hold", busy, 1'b1);
    done_pulse();
    chk("t1_busy_low", busy, 1'b0);
    chk("t1_frame_count", fc, 1);

    // drop while busy, then overrun_clr
    tick_in = ~tick_in; expect_frame();
    step(4);
    tick_in = ~tick_in;
    step(4);
    exp_dc = 1;
    chk("t2_dropped", dc, exp_dc);
    chk("t2_overrun", ovr, 1'b1);
    chk("t2_frame_count", fc, 2);
    overrun_clr = 1'b1;
    step(1);
    overrun_clr = 1'b0;
    chk("t2_overrun_clr", ovr, 1'b0);
    chk("t2_dropped_kept", dc, exp_dc);

    // edge coincident with render_done is accepted
    tick_in = ~tick_in;
    step(2);
    render_done = 1'b1; expect_frame();
    step(1);
    render_done = 1'b0;
    chk("t3_start", fs, 1'b1);
    chk("t3_dropped", dc, exp_dc);
    chk("t3_frame_count", fc, 3);
    step(2);
    done_pulse();

    // watchdog
    tick_in = ~tick_in; expect_frame();
    wait_start("t4_start", 20, n);
    n = 0;
    while (lost !== 1'b1 && n < 200) begin
      render_done = (n == 2);
      step(1);
      n++;
    end
    render_done = 1'b0;
    chk("t4_lost_cycle", n, TOUT);
    step(45);
    chk("t4_lost_held", lost, 1'b1);
    chk("t4_fsm_unaffected", busy, 1'b0);
    tick_in = ~tick_in; expect_frame();
    step(2);
    chk("t4_lost_before_edge", lost, 1'b1);
    step(1);
    chk("t4_edge_start", fs, 1'b1);
    chk("t4_lost_clear", lost, 1'b0);
    step(2);
    done_pulse();

    // dropped_count saturation
    tick_in = ~tick_in; expect_frame();
    step(4);
    for (int i = 0; i < 5; i++) begin
      tick_in = ~tick_in;
      step(4);
      exp_dc = (exp_dc == 3) ? 3 : exp_dc + 1;
      chk("t5_dropped_sat", dc, exp_dc);
    end
    chk("t5_overrun", ovr, 1'b1);
    done_pulse();
    step(2);

    // async reset mid-frame
    tick_in = ~tick_in; expect_frame();
    step(5);
    chk("t6_busy_before", busy, 1'b1);
    #3 resetn = 1'b0;
    #1;
    chk("t6_async_busy", busy, 1'b0);
    chk("t6_async_count", fc, 0);
    chk("t6_async_dropped", dc, 0);
    chk("t6_async_overrun", ovr, 1'b0);
    tick_in = 1'b0;
    step(3);
    resetn = 1'b1;
    exp_fc = 0; exp_dc = 0;
    step(20);
    chk("t6_no_frame_count", fc, 0);
    chk("t6_no_busy", busy, 1'b0);

    // frame_count wrap after 17 frames
    for (int i = 0; i < 17; i++) begin
      tick_in = ~tick_in; expect_frame();
      step(4);
      done_pulse();
      step(1);
    end
    chk("t5_frame_wrap", fc, 1);
    chk("t5_no_drops", dc, 0);

    // rising-edge-only instance
    pulses_b = 0;
    for (int i = 0; i < 4; i++) begin
      tick_b = ~tick_b;
      step(5);
      done_pulse();
      step(2);
    end
    chk("t7_pulses", pulses_b, 2);
    chk("t7_frame_count", fc_b, 2);
    chk("t7_dropped", dc_b, 0);
    chk("t7_overrun", ovr_b, 1'b0);
    chk("t7_busy", busy_b, 1'b0);
    chk("t7_lost", lost_b, 1'b0);

    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
